// File: rtl/alu_pkg.sv
// Purpose: shared types and constants for the ALU operation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // ALU operation codes driven towards the execute stage
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_MUL = 4'b0010,
        ALU_DIV = 4'b0011,
        ALU_AND = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_NOR = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SLT = 4'b1001,
        ALU_XOR = 4'b1010
    } alu_op_t;

    // R-type function field encodings (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_MUL = 6'b000010;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000011;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;

    // Main-control ALUOp field
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Purpose: combinational aluop + funct decode into ALU op, multicycle and illegal flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to capture the result.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output alu_op_t    alu_op_o,
    output logic       multicycle_o,
    output logic       illegal_o
);

    // Unknown functs and the reserved aluop fall back to ADD but are flagged
    always_comb begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: alu_op_o = ALU_ADD;
            ALUOP_SUB: alu_op_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_op_o = ALU_ADD;
                    FUNCT_SUB: alu_op_o = ALU_SUB;
                    FUNCT_MUL: alu_op_o = ALU_MUL;
                    FUNCT_DIV: alu_op_o = ALU_DIV;
                    FUNCT_AND: alu_op_o = ALU_AND;
                    FUNCT_OR:  alu_op_o = ALU_OR;
                    FUNCT_NOR: alu_op_o = ALU_NOR;
                    FUNCT_SLL: alu_op_o = ALU_SLL;
                    FUNCT_SRL: alu_op_o = ALU_SRL;
                    FUNCT_SLT: alu_op_o = ALU_SLT;
                    FUNCT_XOR: alu_op_o = ALU_XOR;
                    default: begin
                        alu_op_o  = ALU_ADD;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_op_o  = ALU_ADD;
                illegal_o = 1'b1;
            end
        endcase
    end

    // Only legally decoded MUL/DIV occupy the ALU for several cycles
    assign multicycle_o = (alu_op_o == ALU_MUL) || (alu_op_o == ALU_DIV);

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: registered ALU-control decoder with valid/ready handshake and MUL/DIV occupancy hold-off.
// Latency: op accepted at edge N is presented (out_valid) in cycle N+1.
// Backpressure: outputs held stable until out_ready; no intake during multi-cycle occupancy.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [1:0]        aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_op,
    output logic              multicycle,
    output logic              illegal,
    output logic              busy
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_op_t          op_q, op_d;
    logic             mc_q, mc_d;
    logic             ill_q, ill_d;

    alu_op_t dec_op;
    logic    dec_mc;
    logic    dec_ill;
    logic    accept;

    // Only the funct field matters; upper instruction bits are intentionally unused
    generate
        if (DATA_W > 6) begin : g_hi_bits
            logic unused_instr_hi;
            assign unused_instr_hi = ^instr[DATA_W-1:6];
        end
    endgenerate

    alu_funct_decode u_decode (
        .aluop_i      (aluop),
        .funct_i      (instr[5:0]),
        .alu_op_o     (dec_op),
        .multicycle_o (dec_mc),
        .illegal_o    (dec_ill)
    );

    // Intake is open when idle, or when the current single-cycle op retires this cycle
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state_q == ST_IDLE) ||
                       ((state_q == ST_ISSUE) && out_ready && !mc_q);
        end
    end

    assign accept = in_valid && in_ready;

    // Next-state logic: capture decode, issue, and count down multi-cycle occupancy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mc_d    = mc_q;
        ill_d   = ill_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = dec_op;
                    mc_d    = dec_mc;
                    ill_d   = dec_ill;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (out_ready) begin
                    if (mc_q) begin
                        cnt_d   = (op_q == ALU_MUL) ? MUL_LOAD : DIV_LOAD;
                        state_d = ST_WAIT;
                    end else if (accept) begin
                        op_d  = dec_op;
                        mc_d  = dec_mc;
                        ill_d = dec_ill;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending or in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= ALU_ADD;
            mc_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mc_q    <= mc_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid  = (state_q == ST_ISSUE);
    assign busy       = (state_q == ST_WAIT);
    assign alu_op     = op_q;
    assign multicycle = mc_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: self-checking bench for alu_op_sequencer (vector table, directed corners, random scoreboard).
// Latency: n/a.
// Backpressure: exercised via randomized out_ready.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int MUL_C  = 4;
    localparam int DIV_C  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] instr;
    logic [1:0]        aluop;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_op;
    logic              multicycle;
    logic              illegal;
    logic              busy;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .aluop      (aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .multicycle (multicycle),
        .illegal    (illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference decode: legal functs listed in op-code order, so the index is the code
    localparam logic [5:0] REF_FUNCT [11] = '{
        6'b100000, 6'b100010, 6'b000010, 6'b011010, 6'b100100, 6'b100101,
        6'b100111, 6'b000000, 6'b000011, 6'b101010, 6'b100110
    };

    typedef struct {
        logic [3:0] op;
        logic       mc;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [3:0] op;
        logic       mc;
        logic       ill;
    } vec_t;

    function automatic exp_t ref_decode(input logic [1:0] a, input logic [5:0] f);
        exp_t e;
        e.op  = 4'd0;
        e.ill = 1'b0;
        if (a == 2'd1) begin
            e.op = 4'd1;
        end else if (a == 2'd3) begin
            e.ill = 1'b1;
        end else if (a == 2'd2) begin
            e.ill = 1'b1;
            for (int i = 0; i < 11; i++) begin
                if (REF_FUNCT[i] == f) begin
                    e.op  = 4'(i);
                    e.ill = 1'b0;
                end
            end
        end
        e.mc = (e.op == 4'd2) || (e.op == 4'd3);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] a, input logic [5:0] f);
        in_valid   = v;
        aluop      = a;
        instr      = $urandom;
        instr[5:0] = f;
    endtask

    // Waits (bounded) until the block is idle and able to accept
    task automatic wait_idle();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL wait_idle: in_ready still 0 after %0d cycles", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [16];
        exp_t q [$];
        exp_t e;
        int   busy_left;
        logic exp_ov, exp_busy, exp_rdy;
        logic [5:0] f;

        vecs[0]  = '{2'b10, 6'b100000, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 6'b100010, 4'b0001, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 6'b000010, 4'b0010, 1'b1, 1'b0};
        vecs[3]  = '{2'b10, 6'b011010, 4'b0011, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 6'b100100, 4'b0100, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 6'b100101, 4'b0101, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 6'b100111, 4'b0110, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'b000000, 4'b0111, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 6'b000011, 4'b1000, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 6'b101010, 4'b1001, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 6'b100110, 4'b1010, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 6'b111111, 4'b0000, 1'b0, 1'b1};
        vecs[12] = '{2'b11, 6'b100010, 4'b0000, 1'b0, 1'b1};
        vecs[13] = '{2'b01, 6'b111111, 4'b0001, 1'b0, 1'b0};
        vecs[14] = '{2'b00, 6'b011010, 4'b0000, 1'b0, 1'b0};
        vecs[15] = '{2'b10, 6'b010101, 4'b0000, 1'b0, 1'b1};

        // Reset state
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; instr = '0; aluop = 2'b00;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // AND, one cycle after acceptance
        set_in(1'b1, 2'b10, FUNCT_AND); out_ready = 1'b1;
        tick(); in_valid = 1'b0; #1;
        chk("and_valid", 32'(out_valid), 32'd1);
        chk("and_op", 32'(alu_op), 32'h4);
        chk("and_illegal", 32'(illegal), 32'd0);
        chk("and_busy", 32'(busy), 32'd0);
        tick();
        chk("and_done", 32'(out_valid), 32'd0);
        chk("and_busy2", 32'(busy), 32'd0);

        // Back-to-back ADD, SUB, XOR
        set_in(1'b1, 2'b10, FUNCT_ADD); out_ready = 1'b1; #1;
        chk("b2b_rdy0", 32'(in_ready), 32'd1);
        tick(); set_in(1'b1, 2'b10, FUNCT_SUB); #1;
        chk("b2b_op0", 32'(alu_op), 32'h0);
        chk("b2b_vld0", 32'(out_valid), 32'd1);
        chk("b2b_rdy1", 32'(in_ready), 32'd1);
        tick(); set_in(1'b1, 2'b10, FUNCT_XOR); #1;
        chk("b2b_op1", 32'(alu_op), 32'h1);
        chk("b2b_rdy2", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; #1;
        chk("b2b_op2", 32'(alu_op), 32'hA);
        chk("b2b_vld2", 32'(out_valid), 32'd1);
        tick();
        chk("b2b_end", 32'(out_valid), 32'd0);

        // MUL occupancy with a DIV offered throughout
        set_in(1'b1, 2'b10, FUNCT_MUL); out_ready = 1'b1;
        tick(); set_in(1'b1, 2'b10, FUNCT_DIV); #1;
        chk("mul_op", 32'(alu_op), 32'h2);
        chk("mul_mc", 32'(multicycle), 32'd1);
        chk("mul_rdy", 32'(in_ready), 32'd0);
        tick();
        for (int k = 0; k < MUL_C; k++) begin
            chk($sformatf("mul_busy%0d", k), 32'(busy), 32'd1);
            chk($sformatf("mul_wait_rdy%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("mul_wait_vld%0d", k), 32'(out_valid), 32'd0);
            tick();
        end
        chk("mul_busy_end", 32'(busy), 32'd0);
        chk("mul_rdy_end", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; #1;
        chk("div_after_op", 32'(alu_op), 32'h3);
        chk("div_after_vld", 32'(out_valid), 32'd1);
        tick();
        wait_idle();

        // SLT held under backpressure
        set_in(1'b1, 2'b10, FUNCT_SLT); out_ready = 1'b0;
        tick(); set_in(1'b1, 2'b10, FUNCT_ADD);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("slt_vld%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("slt_op%0d", k), 32'(alu_op), 32'h9);
            chk($sformatf("slt_rdy%0d", k), 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; #1;
        chk("slt_final_op", 32'(alu_op), 32'h9);
        tick();
        chk("slt_retired", 32'(out_valid), 32'd0);

        // Reset in the second WAIT cycle of a DIV
        set_in(1'b1, 2'b10, FUNCT_DIV); out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        chk("div_wait1_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b1; #1;
        chk("div_rst_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("div_rst_busy", 32'(busy), 32'd0);
        chk("div_rst_vld", 32'(out_valid), 32'd0);
        chk("div_rst_op", 32'(alu_op), 32'd0);
        chk("div_rst_mc", 32'(multicycle), 32'd0);
        rst = 1'b0; #1;
        chk("div_rst_rdy_after", 32'(in_ready), 32'd1);

        // Decode vector table
        for (int i = 0; i < 16; i++) begin
            wait_idle();
            set_in(1'b1, vecs[i].aluop, vecs[i].funct);
            tick(); in_valid = 1'b0; #1;
            chk($sformatf("vec%0d_vld", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_op", i), 32'(alu_op), 32'(vecs[i].op));
            chk($sformatf("vec%0d_mc", i), 32'(multicycle), 32'(vecs[i].mc));
            chk($sformatf("vec%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        wait_idle();

        // Randomized traffic against a transaction-level model
        busy_left = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            aluop     = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
            f         = ($urandom_range(0, 3) == 0) ? 6'($urandom) : REF_FUNCT[$urandom_range(0, 10)];
            instr      = $urandom;
            instr[5:0] = f;
            #1;
            exp_ov   = (q.size() != 0);
            exp_busy = (busy_left > 0);
            exp_rdy  = !exp_busy && (!exp_ov || (out_ready && !q[0].mc));
            chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
            chk("rnd_busy", 32'(busy), 32'(exp_busy));
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            if (exp_ov) begin
                chk("rnd_alu_op", 32'(alu_op), 32'(q[0].op));
                chk("rnd_multicycle", 32'(multicycle), 32'(q[0].mc));
                chk("rnd_illegal", 32'(illegal), 32'(q[0].ill));
            end
            if (busy_left > 0) busy_left--;
            if (exp_ov && out_ready) begin
                e = q.pop_front();
                if (e.mc) busy_left = (e.op == 4'd2) ? MUL_C : DIV_C;
            end
            if (in_valid && exp_rdy) q.push_back(ref_decode(aluop, f));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
